ddram_arbiter: RTL and testbench

- Shares the single 64-bit DDRAM Avalon-style port between N clients, such as the ROM loader/cartridge reader, the save-RAM backup and the video capture path.
- Each client uses a toggle req/ack handshake: a request is pending while req != ack.
- Round-robin grant, one outstanding transaction at a time, burst length fixed at 1.
- Sits between client-side caches or adapters and the DDRAM port in the top level.

---
 rtl/ddram_arb_pkg.sv | 8 +
 rtl/ddram_rr_pick.sv | 22 ++
 rtl/ddram_arbiter.sv | 80 ++++++++
 tb/tb_ddram_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ddram_arb_pkg.sv
// ddram_arb_pkg: shared types and widths for the DDRAM client arbiter
package ddram_arb_pkg;
  typedef enum logic [1:0] {IDLE, CMD, RDWAIT} state_t;
  localparam int ADDR_W = 25;
  localparam int DATA_W = 64;
  localparam int BE_W = 8;
  localparam logic [7:0] BURST_ONE = 8'd1;
endpackage

// File: rtl/ddram_rr_pick.sv
// ddram_rr_pick: combinational round-robin picker starting after the last grant
module ddram_rr_pick #(
  parameter int N = 3
) (
  input  logic [N-1:0]         pending,
  input  logic [$clog2(N)-1:0] last,
  output logic                 valid,
  output logic [$clog2(N)-1:0] grant
);
  localparam int LW = $clog2(N);
  int idx;
  // walk the ring from farthest to nearest so the nearest pending client after last wins
  always_comb begin
    valid = |pending;
    grant = '0;
    idx = 0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(last) + k) % N;
      if (pending[LW'(idx)]) grant = LW'(idx);
    end
  end
endmodule

// File: rtl/ddram_arbiter.sv
// ddram_arbiter: round-robin toggle-handshake sharing of one 64-bit DDRAM port
module ddram_arbiter
  import ddram_arb_pkg::*;
#(
  parameter int N = 3,
  parameter logic [3:0] BASE = 4'b0011
) (
  input  logic                 DDRAM_CLK,
  input  logic                 reset,
  input  logic                 DDRAM_BUSY,
  output logic [7:0]           DDRAM_BURSTCNT,
  output logic [28:0]          DDRAM_ADDR,
  output logic                 DDRAM_RD,
  output logic                 DDRAM_WE,
  output logic [63:0]          DDRAM_DIN,
  output logic [7:0]           DDRAM_BE,
  input  logic [63:0]          DDRAM_DOUT,
  input  logic                 DDRAM_DOUT_READY,
  input  logic [N-1:0]         cl_req,
  output logic [N-1:0]         cl_ack,
  input  logic [N-1:0]         cl_we,
  input  logic [N*ADDR_W-1:0]  cl_addr,
  input  logic [N*DATA_W-1:0]  cl_din,
  input  logic [N*BE_W-1:0]    cl_be,
  output logic [N*DATA_W-1:0]  cl_dout
);
  localparam int LW = $clog2(N);
  state_t state, state_n;
  logic [LW-1:0] last_grant, cur, pick;
  logic pick_valid, issue, accept, rd_done;
  assign DDRAM_BURSTCNT = BURST_ONE;
  ddram_rr_pick #(.N(N)) u_pick (
    .pending(cl_req ^ cl_ack),
    .last(last_grant),
    .valid(pick_valid),
    .grant(pick)
  );
  // transaction sequencing; WE still high at the accepting edge tells write from read
  always_comb begin
    issue = state == IDLE && pick_valid;
    accept = state == CMD && !DDRAM_BUSY;
    rd_done = state == RDWAIT && DDRAM_DOUT_READY;
    state_n = issue ? CMD : accept ? (DDRAM_WE ? IDLE : RDWAIT) : rd_done ? IDLE : state;
  end
  // state register
  always_ff @(posedge DDRAM_CLK) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  // command latch, ack toggling and read data capture for the granted client
  always_ff @(posedge DDRAM_CLK) begin
    if (reset) begin
      last_grant <= LW'(N - 1);
      cur <= '0;
      DDRAM_ADDR <= {BASE, 25'd0};
      DDRAM_RD <= 1'b0;
      DDRAM_WE <= 1'b0;
      DDRAM_DIN <= '0;
      DDRAM_BE <= '0;
      cl_ack <= '0;
      cl_dout <= '0;
    end else begin
      if (issue) begin
        cur <= pick;
        last_grant <= pick;
        DDRAM_ADDR <= {BASE, cl_addr[int'(pick)*ADDR_W +: ADDR_W]};
        DDRAM_DIN <= cl_din[int'(pick)*DATA_W +: DATA_W];
        DDRAM_BE <= cl_we[pick] ? cl_be[int'(pick)*BE_W +: BE_W] : 8'hFF;
        DDRAM_RD <= !cl_we[pick];
        DDRAM_WE <= cl_we[pick];
      end
      if (accept) begin
        DDRAM_RD <= 1'b0;
        DDRAM_WE <= 1'b0;
      end
      if ((accept && DDRAM_WE) || rd_done) cl_ack[cur] <= ~cl_ack[cur];
      if (rd_done) cl_dout[int'(cur)*DATA_W +: DATA_W] <= DDRAM_DOUT;
    end
  end
endmodule

// File: tb/tb_ddram_arbiter.sv
// tb_ddram_arbiter: directed vector bench for the DDRAM arbiter
module tb_ddram_arbiter;
  localparam int N = 3;
  logic DDRAM_CLK = 1'b0;
  logic reset, DDRAM_BUSY, DDRAM_RD, DDRAM_WE, DDRAM_DOUT_READY;
  logic [7:0] DDRAM_BURSTCNT, DDRAM_BE;
  logic [28:0] DDRAM_ADDR;
  logic [63:0] DDRAM_DIN, DDRAM_DOUT;
  logic [N-1:0] cl_req, cl_ack, cl_we;
  logic [N*25-1:0] cl_addr;
  logic [N*64-1:0] cl_din, cl_dout;
  logic [N*8-1:0] cl_be;
  int n_cmp = 0, n_bad = 0;
  int rd_acc = 0, wr_acc = 0, both = 0;
  logic [63:0] exp_dout [N];

  typedef struct {
    int c;
    bit we;
    logic [24:0] addr;
    logic [63:0] data;
    logic [7:0] be;
    int lat;
    int busy;
    logic [7:0] exp_be;
  } vec_t;
  vec_t vecs [6];

  ddram_arbiter #(.N(N), .BASE(4'b0011)) dut (
    .DDRAM_CLK(DDRAM_CLK), .reset(reset), .DDRAM_BUSY(DDRAM_BUSY),
    .DDRAM_BURSTCNT(DDRAM_BURSTCNT), .DDRAM_ADDR(DDRAM_ADDR), .DDRAM_RD(DDRAM_RD),
    .DDRAM_WE(DDRAM_WE), .DDRAM_DIN(DDRAM_DIN), .DDRAM_BE(DDRAM_BE),
    .DDRAM_DOUT(DDRAM_DOUT), .DDRAM_DOUT_READY(DDRAM_DOUT_READY),
    .cl_req(cl_req), .cl_ack(cl_ack), .cl_we(cl_we), .cl_addr(cl_addr),
    .cl_din(cl_din), .cl_be(cl_be), .cl_dout(cl_dout)
  );

  always #5 DDRAM_CLK = ~DDRAM_CLK;

  always @(posedge DDRAM_CLK) begin
    if (!reset) begin
      if (DDRAM_RD && !DDRAM_BUSY) rd_acc++;
      if (DDRAM_WE && !DDRAM_BUSY) wr_acc++;
      if (DDRAM_RD && DDRAM_WE) both++;
    end
  end

  task automatic tick();
    @(posedge DDRAM_CLK);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cl_req = '0;
    tick();
    tick();
    reset = 1'b0;
    for (int k = 0; k < N; k++) exp_dout[k] = '0;
  endtask

  task automatic check_douts(input string nm);
    for (int k = 0; k < N; k++) check(nm, cl_dout[k*64 +: 64], exp_dout[k]);
  endtask

  task automatic run_vec(input vec_t v);
    logic [N-1:0] a0, m;
    int r0, w0;
    a0 = cl_ack;
    m = '0;
    m[v.c] = 1'b1;
    r0 = rd_acc;
    w0 = wr_acc;
    cl_we[v.c] = v.we;
    cl_addr[v.c*25 +: 25] = v.addr;
    cl_din[v.c*64 +: 64] = v.data;
    cl_be[v.c*8 +: 8] = v.be;
    cl_req[v.c] = ~cl_req[v.c];
    tick();
    check("cmd_rd", 64'(DDRAM_RD), 64'(!v.we));
    check("cmd_we", 64'(DDRAM_WE), 64'(v.we));
    check("cmd_addr", 64'(DDRAM_ADDR), 64'({4'b0011, v.addr}));
    check("cmd_be", 64'(DDRAM_BE), 64'(v.exp_be));
    check("burstcnt", 64'(DDRAM_BURSTCNT), 64'd1);
    if (v.we) check("cmd_din", DDRAM_DIN, v.data);
    if (v.busy > 0) begin
      DDRAM_BUSY = 1'b1;
      for (int i = 0; i < v.busy; i++) begin
        tick();
        check("hold_rd", 64'(DDRAM_RD), 64'(!v.we));
        check("hold_we", 64'(DDRAM_WE), 64'(v.we));
        check("hold_addr", 64'(DDRAM_ADDR), 64'({4'b0011, v.addr}));
        check("hold_be", 64'(DDRAM_BE), 64'(v.exp_be));
      end
      DDRAM_BUSY = 1'b0;
    end
    tick();
    check("drop_rd", 64'(DDRAM_RD), 64'd0);
    check("drop_we", 64'(DDRAM_WE), 64'd0);
    if (v.we) check("wr_ack", 64'(cl_ack), 64'(a0 ^ m));
    else begin
      check("rd_ack_early", 64'(cl_ack), 64'(a0));
      for (int i = 0; i < v.lat - 1; i++) begin
        tick();
        check("rd_ack_wait", 64'(cl_ack), 64'(a0));
      end
      DDRAM_DOUT = v.data;
      DDRAM_DOUT_READY = 1'b1;
      tick();
      DDRAM_DOUT_READY = 1'b0;
      check("rd_ack", 64'(cl_ack), 64'(a0 ^ m));
      exp_dout[v.c] = v.data;
    end
    check_douts("dout");
    check("rd_issued", 64'(rd_acc - r0), 64'(!v.we));
    check("wr_issued", 64'(wr_acc - w0), 64'(v.we));
  endtask

  initial begin
    logic [N-1:0] a0;
    int r0, w0, g;
    vecs[0] = '{c: 1, we: 1, addr: 25'h000123, data: 64'hDEADBEEF_CAFEF00D, be: 8'h0F, lat: 0, busy: 0, exp_be: 8'h0F};
    vecs[1] = '{c: 0, we: 0, addr: 25'h0000010, data: 64'h0123456789ABCDEF, be: 8'h00, lat: 5, busy: 0, exp_be: 8'hFF};
    vecs[2] = '{c: 2, we: 1, addr: 25'h1FFFFFF, data: 64'hFFFF_FFFF_FFFF_FFFF, be: 8'h00, lat: 0, busy: 0, exp_be: 8'h00};
    vecs[3] = '{c: 2, we: 0, addr: 25'h0AAAAAA, data: 64'h5555_AAAA_5555_AAAA, be: 8'h3C, lat: 1, busy: 2, exp_be: 8'hFF};
    vecs[4] = '{c: 0, we: 0, addr: 25'h0000010, data: 64'hFEED_FACE_0BAD_CAFE, be: 8'h00, lat: 2, busy: 4, exp_be: 8'hFF};
    vecs[5] = '{c: 1, we: 1, addr: 25'h1234567, data: 64'h1122334455667788, be: 8'h80, lat: 0, busy: 1, exp_be: 8'h80};
    cl_we = '0; cl_addr = '0; cl_din = '0; cl_be = '0;
    DDRAM_BUSY = 1'b0; DDRAM_DOUT = '0; DDRAM_DOUT_READY = 1'b0;
    do_reset();
    check("rst_ack", 64'(cl_ack), 64'd0);
    check("rst_rd", 64'(DDRAM_RD), 64'd0);
    check("rst_we", 64'(DDRAM_WE), 64'd0);
    check("rst_addr", 64'(DDRAM_ADDR), 64'(29'h06000000));
    check("rst_be", 64'(DDRAM_BE), 64'd0);
    check("rst_din", DDRAM_DIN, 64'd0);
    check_douts("rst_dout");
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);
    // stray read data while idle must be ignored
    a0 = cl_ack;
    DDRAM_DOUT = 64'hBAD0BAD0BAD0BAD0;
    DDRAM_DOUT_READY = 1'b1;
    tick();
    DDRAM_DOUT_READY = 1'b0;
    tick();
    check("stray_ack", 64'(cl_ack), 64'(a0));
    check_douts("stray_dout");
    check("stray_rd", 64'(DDRAM_RD), 64'd0);
    // round robin: all clients keep writing
    do_reset();
    for (int k = 0; k < N; k++) begin
      cl_we[k] = 1'b1;
      cl_addr[k*25 +: 25] = 25'(32'h100 + k);
    end
    cl_req = '1;
    for (int t = 0; t < 9; t++) begin
      a0 = cl_ack;
      tick();
      g = int'(DDRAM_ADDR[24:0]) - 32'h100;
      check("rr_grant", 64'(g), 64'(t % 3));
      check("rr_we", 64'(DDRAM_WE), 64'd1);
      tick();
      check("rr_ack", 64'(cl_ack ^ a0), 64'(1 << (t % 3)));
      if (t < 8 && g >= 0 && g < N) cl_req[g] = ~cl_req[g];
    end
    // reset while waiting for read data
    do_reset();
    cl_we = '0;
    cl_addr[25 +: 25] = 25'h0000777;
    cl_req[1] = 1'b1;
    tick();
    check("rw_rd", 64'(DDRAM_RD), 64'd1);
    tick();
    r0 = rd_acc;
    w0 = wr_acc;
    tick();
    do_reset();
    DDRAM_DOUT = 64'hCAFE_CAFE_CAFE_CAFE;
    DDRAM_DOUT_READY = 1'b1;
    tick();
    DDRAM_DOUT_READY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rr_idle_rd", 64'(DDRAM_RD), 64'd0);
      check("rr_idle_we", 64'(DDRAM_WE), 64'd0);
    end
    check("rrst_ack", 64'(cl_ack), 64'd0);
    check_douts("rrst_dout");
    check("rrst_rd_cnt", 64'(rd_acc - r0), 64'd0);
    check("rrst_wr_cnt", 64'(wr_acc - w0), 64'd0);
    check("rd_we_overlap", 64'(both), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
